// File: rtl/ex_muldiv_if.sv
// Execute-stage bundle between ID/EX and EX/MEM: operation, operands and result/stall.
// master = pipeline side driving the instruction, slave = the execute stage.
interface ex_muldiv_if #(
  parameter int DW = 32
);
  logic [7:0]    aluop_i;
  logic [2:0]    alusel_i;
  logic [4:0]    wd_i;
  logic          wreg_i;
  logic [DW-1:0] reg1_i;
  logic [DW-1:0] reg2_i;
  logic          flush_i;
  logic [4:0]    wd_o;
  logic          wreg_o;
  logic [DW-1:0] wdata_o;
  logic          stallreq_o;

  modport master (
    output aluop_i, alusel_i, wd_i, wreg_i, reg1_i, reg2_i, flush_i,
    input  wd_o, wreg_o, wdata_o, stallreq_o
  );

  modport slave (
    input  aluop_i, alusel_i, wd_i, wreg_i, reg1_i, reg2_i, flush_i,
    output wd_o, wreg_o, wdata_o, stallreq_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// Execute stage: combinational logic/shift/move results plus HI/LO and an iterative
// radix-2 multiply/divide (DW BUSY cycles) that holds the pipeline through stallreq_o.
module ex_muldiv #(
  parameter int DW = 32
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus
);
  localparam int SHW = $clog2(DW);

  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_MOVE  = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [DW-1:0]   opb_q, opb_d;
  logic [2*DW-1:0] acc_q, acc_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic            dz_q, dz_d;

  logic            is_mul, is_div, is_signed, md_op;
  logic [DW-1:0]   a_abs, b_abs;
  logic [SHW-1:0]  shamt;
  logic [DW:0]     mul_sum, div_shift, div_diff;
  logic [2*DW-1:0] mul_step, div_step, prod_fix;
  logic [DW-1:0]   quo_fix, rem_fix;

  assign is_mul    = (bus.aluop_i == OP_MULT) || (bus.aluop_i == OP_MULTU);
  assign is_div    = (bus.aluop_i == OP_DIV)  || (bus.aluop_i == OP_DIVU);
  assign is_signed = (bus.aluop_i == OP_MULT) || (bus.aluop_i == OP_DIV);
  assign md_op     = is_mul || is_div;
  assign a_abs     = (is_signed && bus.reg1_i[DW-1]) ? -bus.reg1_i : bus.reg1_i;
  assign b_abs     = (is_signed && bus.reg2_i[DW-1]) ? -bus.reg2_i : bus.reg2_i;
  assign shamt     = bus.reg1_i[SHW-1:0];

  // acc holds {partial product, remaining multiplier} or {remainder, quotient}
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_step  = {mul_sum, acc_q[DW-1:1]};
    div_shift = {acc_q[2*DW-1:DW], acc_q[DW-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_step  = div_diff[DW] ? {div_shift[DW-1:0], acc_q[DW-2:0], 1'b0}
                             : {div_diff[DW-1:0],  acc_q[DW-2:0], 1'b1};
    prod_fix  = neg_q  ? -acc_q : acc_q;
    quo_fix   = neg_q  ? -acc_q[DW-1:0]    : acc_q[DW-1:0];
    rem_fix   = rneg_q ? -acc_q[2*DW-1:DW] : acc_q[2*DW-1:DW];
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (md_op && !bus.flush_i) begin
          is_div_d = is_div;
          cnt_d    = '0;
          rneg_d   = is_signed && bus.reg1_i[DW-1];
          neg_d    = is_signed && (bus.reg1_i[DW-1] ^ bus.reg2_i[DW-1]);
          dz_d     = is_div && (bus.reg2_i == '0);
          opb_d    = is_div ? b_abs : a_abs;
          acc_d    = {{DW{1'b0}}, (is_div ? a_abs : b_abs)};
          // a zero divisor skips the iteration; the raw dividend becomes HI
          if (is_div && (bus.reg2_i == '0)) begin
            acc_d   = {{DW{1'b0}}, bus.reg1_i};
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div_q ? div_step : mul_step;
          cnt_d = cnt_q + SHW'(1);
          if (cnt_q == SHW'(DW - 1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!bus.flush_i) begin
          if (dz_q) begin
            hi_d = acc_q[DW-1:0];
            lo_d = '1;
          end else if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*DW-1:DW];
            lo_d = prod_fix[DW-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
    end
  end

  always_comb begin
    bus.wd_o       = bus.wd_i;
    bus.wreg_o     = bus.wreg_i && !md_op;
    bus.wdata_o    = '0;
    bus.stallreq_o = 1'b0;
    case (bus.alusel_i)
      RES_LOGIC: begin
        case (bus.aluop_i)
          OP_AND:  bus.wdata_o = bus.reg1_i & bus.reg2_i;
          OP_OR:   bus.wdata_o = bus.reg1_i | bus.reg2_i;
          OP_XOR:  bus.wdata_o = bus.reg1_i ^ bus.reg2_i;
          OP_NOR:  bus.wdata_o = ~(bus.reg1_i | bus.reg2_i);
          default: bus.wdata_o = '0;
        endcase
      end
      RES_SHIFT: begin
        case (bus.aluop_i)
          OP_SLL:  bus.wdata_o = bus.reg2_i << shamt;
          OP_SRL:  bus.wdata_o = bus.reg2_i >> shamt;
          OP_SRA:  bus.wdata_o = $unsigned($signed(bus.reg2_i) >>> shamt);
          default: bus.wdata_o = '0;
        endcase
      end
      RES_MOVE: begin
        case (bus.aluop_i)
          OP_MFHI: bus.wdata_o = hi_q;
          OP_MFLO: bus.wdata_o = lo_q;
          default: bus.wdata_o = '0;
        endcase
      end
      default: bus.wdata_o = '0;
    endcase
    if (!bus.flush_i) begin
      case (state_q)
        S_IDLE:  bus.stallreq_o = md_op;
        S_BUSY:  bus.stallreq_o = 1'b1;
        default: bus.stallreq_o = 1'b0;
      endcase
    end
    if (!rst) begin
      bus.wd_o       = '0;
      bus.wreg_o     = 1'b0;
      bus.wdata_o    = '0;
      bus.stallreq_o = 1'b0;
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus queues expected results and stall lengths,
// a negedge monitor pops and compares them.
module tb_ex_muldiv;
  localparam int DW = 32;

  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
  localparam logic [7:0] OP_NOP   = 8'b0000_0000;

  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_MOVE  = 3'b011;

  typedef struct {
    string       name;
    logic [31:0] wdata;
    logic        wreg;
    logic [4:0]  wd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic chk_vld = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   stall_run = 0;
  int   tag_n = 1;
  exp_t exp_q[$];
  int   stall_q[$];

  always #5 clk = ~clk;

  ex_muldiv_if #(.DW(DW)) bus ();
  ex_muldiv #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: output checks when a tracked instruction is in EX, stall run lengths on release
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_run = 0;
      end else begin
        if (chk_vld) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: output with no expectation queued");
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, " wdata"}, 64'(bus.wdata_o), 64'(e.wdata));
            check({e.name, " wreg"},  64'(bus.wreg_o),  64'(e.wreg));
            check({e.name, " wd"},    64'(bus.wd_o),    64'(e.wd));
          end
        end
        if (bus.stallreq_o) begin
          stall_run++;
        end else if (stall_run > 0) begin
          if (stall_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL stall run: %0d cycles with no expectation", stall_run);
          end else begin
            check("stall length", 64'(stall_run), 64'(stall_q.pop_front()));
          end
          stall_run = 0;
        end
      end
    end
  end

  task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] r1, input logic [31:0] r2);
    bus.aluop_i  = op;
    bus.alusel_i = sel;
    bus.reg1_i   = r1;
    bus.reg2_i   = r2;
  endtask

  // called at posedge+1; presents one instruction for one cycle
  task automatic issue(input string name, input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] ew, input logic ewr);
    exp_t e;
    e.name  = name;
    e.wdata = ew;
    e.wreg  = ewr;
    e.wd    = 5'(tag_n);
    exp_q.push_back(e);
    drive(op, sel, r1, r2);
    bus.wd_i   = 5'(tag_n);
    bus.wreg_i = 1'b1;
    tag_n++;
    chk_vld = 1'b1;
    @(posedge clk);
    #1 chk_vld = 1'b0;
  endtask

  task automatic muldiv(input string name, input logic [7:0] op,
                        input logic [31:0] r1, input logic [31:0] r2, input int exp_stall);
    bit released = 0;
    stall_q.push_back(exp_stall);
    issue(name, op, RES_NOP, r1, r2, 32'h0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.stallreq_o) begin
        released = 1;
        break;
      end
    end
    if (!released) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: stall never released, got 1 expected 0", name);
    end
    @(posedge clk);
    #1 drive(OP_NOP, RES_NOP, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    bus.flush_i = 1'b0;
    bus.wd_i    = 5'd9;
    bus.wreg_i  = 1'b1;
    drive(OP_OR, RES_LOGIC, 32'h0F0F_0000, 32'h0000_00FF);
    #1;
    check("reset wdata", 64'(bus.wdata_o), 64'h0);
    check("reset wreg",  64'(bus.wreg_o),  64'h0);
    check("reset wd",    64'(bus.wd_o),    64'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    issue("OR",       OP_OR,  RES_LOGIC, 32'h0F0F_0000, 32'h0000_00FF, 32'h0F0F_00FF, 1'b1);
    issue("NOR",      OP_NOR, RES_LOGIC, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1);
    issue("AND",      OP_AND, RES_LOGIC, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b1);
    issue("XOR",      OP_XOR, RES_LOGIC, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b1);
    issue("SRA",      OP_SRA, RES_SHIFT, 32'h4, 32'h8000_0010, 32'hF800_0001, 1'b1);
    issue("SRL",      OP_SRL, RES_SHIFT, 32'h4, 32'h8000_0010, 32'h0800_0001, 1'b1);
    issue("SLL amt0", OP_SLL, RES_SHIFT, 32'h20, 32'h1234_5678, 32'h1234_5678, 1'b1);
    issue("SLL 4",    OP_SLL, RES_SHIFT, 32'h4, 32'h1234_5678, 32'h2345_6780, 1'b1);
    issue("SRA 31",   OP_SRA, RES_SHIFT, 32'h1F, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue("bad op",   8'hEE,  RES_LOGIC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1);
    issue("bad sel",  OP_OR,  3'b111,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1);

    muldiv("MULT -3*7", OP_MULT, 32'hFFFF_FFFD, 32'h7, 33);
    issue("MFHI mult", OP_MFHI, RES_MOVE, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1);
    issue("MFLO mult", OP_MFLO, RES_MOVE, 32'h0, 32'h0, 32'hFFFF_FFEB, 1'b1);

    muldiv("MULTU", OP_MULTU, 32'hFFFF_FFFF, 32'h2, 33);
    issue("MFHI multu", OP_MFHI, RES_MOVE, 32'h0, 32'h0, 32'h0000_0001, 1'b1);
    issue("MFLO multu", OP_MFLO, RES_MOVE, 32'h0, 32'h0, 32'hFFFF_FFFE, 1'b1);

    muldiv("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'h2, 33);
    issue("MFLO div", OP_MFLO, RES_MOVE, 32'h0, 32'h0, 32'hFFFF_FFFD, 1'b1);
    issue("MFHI div", OP_MFHI, RES_MOVE, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1);

    muldiv("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33);
    issue("MFLO ovf", OP_MFLO, RES_MOVE, 32'h0, 32'h0, 32'h8000_0000, 1'b1);
    issue("MFHI ovf", OP_MFHI, RES_MOVE, 32'h0, 32'h0, 32'h0, 1'b1);

    muldiv("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 33);
    issue("MFLO divu", OP_MFLO, RES_MOVE, 32'h0, 32'h0, 32'd14, 1'b1);
    issue("MFHI divu", OP_MFHI, RES_MOVE, 32'h0, 32'h0, 32'd2, 1'b1);

    muldiv("DIVU 7/0", OP_DIVU, 32'd7, 32'd0, 1);
    issue("MFLO dz", OP_MFLO, RES_MOVE, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1);
    issue("MFHI dz", OP_MFHI, RES_MOVE, 32'h0, 32'h0, 32'd7, 1'b1);

    // flush on the tenth BUSY cycle must leave HI/LO from 3*5 intact
    muldiv("MULTU 3*5", OP_MULTU, 32'd3, 32'd5, 33);
    stall_q.push_back(10);
    issue("MULT flushed", OP_MULT, RES_NOP, 32'd100, 32'd200, 32'h0, 1'b0);
    repeat (9) @(posedge clk);
    #1 bus.flush_i = 1'b1;
    #1 check("flush stall", 64'(bus.stallreq_o), 64'h0);
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    issue("MFLO flush", OP_MFLO, RES_MOVE, 32'h0, 32'h0, 32'd15, 1'b1);
    issue("MFHI flush", OP_MFHI, RES_MOVE, 32'h0, 32'h0, 32'd0, 1'b1);

    muldiv("MULT after flush", OP_MULT, 32'hFFFF_FFFD, 32'h7, 33);
    issue("MFLO post", OP_MFLO, RES_MOVE, 32'h0, 32'h0, 32'hFFFF_FFEB, 1'b1);

    // asynchronous reset in the middle of BUSY
    issue("MULT reset", OP_MULT, RES_NOP, 32'd100, 32'd200, 32'h0, 1'b0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst stall", 64'(bus.stallreq_o), 64'h0);
    check("arst wd",    64'(bus.wd_o),       64'h0);
    drive(OP_OR, RES_LOGIC, 32'hFFFF_0000, 32'h0000_FFFF);
    #1;
    check("arst wdata", 64'(bus.wdata_o), 64'h0);
    check("arst wreg",  64'(bus.wreg_o),  64'h0);
    drive(OP_NOP, RES_NOP, 32'h0, 32'h0);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    issue("MFHI arst", OP_MFHI, RES_MOVE, 32'h0, 32'h0, 32'h0, 1'b1);
    issue("MFLO arst", OP_MFLO, RES_MOVE, 32'h0, 32'h0, 32'h0, 1'b1);
    muldiv("MULTU arst", OP_MULTU, 32'hFFFF_FFFF, 32'h2, 33);
    issue("MFHI final", OP_MFHI, RES_MOVE, 32'h0, 32'h0, 32'h1, 1'b1);

    drive(OP_NOP, RES_NOP, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    check("pending outputs", 64'(exp_q.size()),   64'h0);
    check("pending stalls",  64'(stall_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Parametrised execute stage for the MIPS-style five-stage core, sitting between ID/EX and EX/MEM.
- Single-cycle ops use combinational result paths, the same as the current EX stage: AND/OR/XOR/NOR logic and barrel shifts.
- Adds internal HI/LO registers, MFHI/MFLO, and an iterative multi-cycle multiply/divide unit with a stall request to pipeline control.

Parameters:
DW, 32, datapath width (>=8, power of two)
SHW, $clog2(DW), shift-amount width (derived; not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
aluop_i  in  8  operation code (EXE_*_OP from defines.v)
alusel_i  in  3  result class: EXE_RES_LOGIC, EXE_RES_SHIFT, EXE_RES_MOVE, EXE_RES_NOP
wd_i  in  5  destination register address
wreg_i  in  1  destination write enable
reg1_i  in  DW  source operand 1 (rs / shift amount)
reg2_i  in  DW  source operand 2 (rt / shifted value)
flush_i  in  1  abort in-flight instruction
wd_o  out  5  = wd_i
wreg_o  out  1  write enable to EX/MEM
wdata_o  out  DW  result
stallreq_o  out  1  hold IF..EX while multi-cycle op runs

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; HI/LO, count and operand/accumulator regs = 0.
  - Combinational outputs forced: wd_o=0, wreg_o=0, wdata_o=0, stallreq_o=0.
- Logic ops (AND/OR/XOR/NOR):
  - Result is combinational, zero latency.
  - NOR = ~(reg1_i|reg2_i).
- Shift ops: amount = reg1_i[SHW-1:0].
  - SLL: reg2_i<<amt.
  - SRL: logical right shift.
  - SRA: sign-filling right shift.
  - Amount 0 passes reg2_i unchanged.
- MFHI/MFLO (alusel MOVE): wdata_o = current HI / LO register value.
- Unknown aluop or alusel: wdata_o=0 (wd_o/wreg_o still pass through).
- MULT/MULTU/DIV/DIVU:
  - wreg_o forced 0 for all four ops.
  - wdata_o=0.
  - Results go only to HI/LO.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, mul/div op present, flush_i=0:
    - stallreq_o=1 (combinational).
    - Latch magnitudes of operands; signed ops take the two's-complement abs value.
    - Latch result sign flags; clear accumulator; count=0.
    - Go to BUSY.
    - Exception: DIV/DIVU with reg2_i==0 goes directly to DONE.
  - BUSY:
    - stallreq_o=1.
    - One radix-2 step per cycle: shift-add for mul, restoring subtract for div.
    - count++; after step count==DW-1, go to DONE.
  - DONE:
    - stallreq_o=0; pipeline advances.
    - Apply sign fixup.
    - Write HI/LO on the edge leaving DONE; go to IDLE.
- Latency:
  - stallreq_o high for DW+1 cycles (IDLE cycle + DW BUSY cycles), then 1 DONE cycle.
  - Divide-by-zero: stallreq_o high for 1 cycle only.
  - An MFHI/MFLO in the immediately following instruction reads the new value.
- Result rules:
  - MULT: HI:LO = signed 2DW-bit product.
  - MULTU: HI:LO = unsigned 2DW-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - DIV signed overflow: -2^(DW-1)/-1 gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient/remainder.
  - Divide by zero (both DIV and DIVU): LO = all ones, HI = dividend.
- flush_i:
  - Highest priority after reset; forces stallreq_o=0 combinationally.
  - Next state is IDLE; HI/LO are not written.
  - A flush during DONE also suppresses the HI/LO write.
  - A flush in IDLE prevents the op from starting.
- The pipeline must hold inputs stable while stallreq_o=1. The block does not re-sample operands after the IDLE cycle.

Test Plan:
- OR 0x0F0F0000,0x000000FF -> wdata_o=0x0F0F00FF same cycle, wreg_o=1. NOR 0,0 -> 0xFFFFFFFF.
- SRA reg2=0x80000010, reg1=4 -> 0xF8000001. SRL same -> 0x08000001. SLL reg1=0x20 (amt 0) -> reg2 unchanged.
- MULT reg1=-3, reg2=7 -> stallreq_o high exactly 33 cycles, wreg_o=0; then MFHI=0xFFFFFFFF, MFLO=0xFFFFFFEB. MULTU 0xFFFFFFFF×2 -> HI=1, LO=0xFFFFFFFE.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/-1 -> LO=0x80000000, HI=0. DIVU 7/0 -> stall 1 cycle, LO=0xFFFFFFFF, HI=7.
- Preload HI/LO via MULTU 3×5; start MULT, assert flush_i on BUSY cycle 10 -> stallreq_o drops that cycle, MFLO still 15. Next MULT runs the full 33 cycles.
- Drive rst=0 asynchronously mid-BUSY -> stallreq_o, wdata_o and wreg_o go to 0 without a clock edge. After release, MFHI/MFLO read 0 and FSM is IDLE.
